// File: rtl/prog_loader_pkg.sv
// Shared types for the program-memory loader: FSM state encoding and error codes.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream writer for the core's program memory: length, payload, XOR checksum.
// Each payload byte produces one registered write strobe; a verified frame releases core_run.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 W,
  output logic [ADDR_SIZE-1:0] ADDR,
  output logic [DATA_SIZE-1:0] DATA_WR,
  output logic                 busy,
  output logic                 core_run,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [ADDR_SIZE:0]   words_written
);

  localparam logic [ADDR_SIZE-1:0] ONE_A   = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   ONE_W   = (ADDR_SIZE + 1)'(1);
  localparam logic [31:0]          MAX_LEN = 32'd1 << ADDR_SIZE;

  loader_state_t          state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_cnt_q, addr_cnt_d;
  logic [DATA_SIZE-1:0]   csum_q, csum_d;
  logic [ADDR_SIZE:0]     remaining_q, remaining_d;
  logic [ADDR_SIZE:0]     words_q, words_d;
  logic                   w_q, w_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   xfer;
  logic [31:0]            len_ext;
  logic                   len_ok;

  assign busy     = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign in_ready = busy;
  assign xfer     = in_valid && in_ready;
  assign len_ext  = 32'(in_data);
  assign len_ok   = (len_ext != 32'd0) && (len_ext <= MAX_LEN);

  assign W             = w_q;
  assign ADDR          = addr_q;
  assign DATA_WR       = data_q;
  assign core_run      = (state_q == DONE);
  assign error         = (state_q == ERR);
  assign err_code      = err_code_q;
  assign words_written = words_q;

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    csum_d      = csum_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    w_d         = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    err_code_d  = err_code_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          addr_cnt_d = base_addr;
          csum_d     = '0;
          words_d    = '0;
          err_code_d = ERR_NONE;
        end
      end
      LEN: begin
        if (abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (xfer) begin
          if (len_ok) begin
            state_d     = DATA;
            remaining_d = len_ext[ADDR_SIZE:0];
            csum_d      = in_data;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end
        end
      end
      DATA: begin
        // A byte arriving together with abort is swallowed without a write.
        if (abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (xfer) begin
          w_d         = 1'b1;
          addr_d      = addr_cnt_q;
          data_d      = in_data;
          csum_d      = csum_q ^ in_data;
          addr_cnt_d  = addr_cnt_q + ONE_A;
          words_d     = words_q + ONE_W;
          remaining_d = remaining_q - ONE_W;
          if (remaining_q == ONE_W) state_d = CSUM;
        end
      end
      CSUM: begin
        if (abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (xfer) begin
          if (in_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      csum_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      w_q         <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      csum_q      <= csum_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule
